// File: rtl/tdm_mux21.sv
// Two-channel round-robin TDM multiplexer with valid/ready on both sides and a registered output stage.
// Optional build macro TDM_MUX_FIXED_PRIO_EN selects strict channel-0 priority instead of round-robin.
module tdm_mux21 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic             v0,
  output logic             r0,
  input  logic [WIDTH-1:0] d1,
  input  logic             v1,
  output logic             r1,
  output logic [WIDTH-1:0] y,
  output logic             s,
  output logic             vld,
  input  logic             rdy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic             last_nxt;
  logic [WIDTH-1:0] y_nxt;
  logic             s_nxt;
  logic             ld;
  logic             g0;
  logic             g1;

  // Grant selection; last only matters when both channels request.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
`ifdef TDM_MUX_FIXED_PRIO_EN
    if (v0) begin
      g0 = 1'b1;
    end else if (v1) begin
      g1 = 1'b1;
    end else begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
`else
    case ({v1, v0})
      2'b01:   g0 = 1'b1;
      2'b10:   g1 = 1'b1;
      2'b11: begin
        if (last) begin
          g0 = 1'b1;
        end else begin
          g1 = 1'b1;
        end
      end
      default: begin
        g0 = 1'b0;
        g1 = 1'b0;
      end
    endcase
`endif
  end

  assign ld  = (state == EMPTY) | rdy;
  assign r0  = ld & g0;
  assign r1  = ld & g1;
  assign vld = (state == FULL);

  // Next-state and next-output word for the single output stage.
  always_comb begin
    state_nxt = state;
    y_nxt     = y;
    s_nxt     = s;
    last_nxt  = last;
    case (state)
      EMPTY, FULL: begin
        if (ld) begin
          if (g0) begin
            state_nxt = FULL;
            y_nxt     = d0;
            s_nxt     = 1'b0;
            last_nxt  = 1'b0;
          end else if (g1) begin
            state_nxt = FULL;
            y_nxt     = d1;
            s_nxt     = 1'b1;
            last_nxt  = 1'b1;
          end else begin
            state_nxt = EMPTY;
          end
        end else begin
          state_nxt = state;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // State and output registers; last resets to 1 so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      y     <= {WIDTH{1'b0}};
      s     <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      y     <= y_nxt;
      s     <= s_nxt;
      last  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_tdm_mux21.sv
// Table-driven bench for tdm_mux21 with a scoreboard of accepted words checked at the output handshake.
module tb_tdm_mux21;

  typedef struct {
    logic       rst;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       rdy;
    logic       er0;
    logic       er1;
    logic       evld;
    logic [7:0] ey;
    logic       es;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d0 = 8'h00;
  logic       v0 = 1'b0;
  logic       r0;
  logic [7:0] d1 = 8'h00;
  logic       v1 = 1'b0;
  logic       r1;
  logic [7:0] y;
  logic       s;
  logic       vld;
  logic       rdy = 1'b0;

  int         errors = 0;
  int         checks = 0;
  logic       m_vld = 1'b0;
  logic [8:0] sb[$];
  vec_t       tbl[$];

  tdm_mux21 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .d0(d0), .v0(v0), .r0(r0),
    .d1(d1), .v1(v1), .r1(r1),
    .y(y), .s(s), .vld(vld), .rdy(rdy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rs, input logic a0, input logic [7:0] b0,
                              input logic a1, input logic [7:0] b1, input logic rd,
                              input logic e0, input logic e1, input logic ev,
                              input logic [7:0] eyv, input logic esv);
    vec_t t;
    t.rst = rs; t.v0 = a0; t.d0 = b0; t.v1 = a1; t.d1 = b1; t.rdy = rd;
    t.er0 = e0; t.er1 = e1; t.evld = ev; t.ey = eyv; t.es = esv;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic run_row(input vec_t r, input int idx);
    logic [8:0] w;
    rst = r.rst; v0 = r.v0; d0 = r.d0; v1 = r.v1; d1 = r.d1; rdy = r.rdy;
    #2;
    chk("r0", idx, {7'd0, r0}, {7'd0, r.er0});
    chk("r1", idx, {7'd0, r1}, {7'd0, r.er1});
    if (r.rst) begin
      sb.delete();
    end else begin
      if (m_vld && r.rdy) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", idx, 8'd0, 8'd1);
        end else begin
          w = sb.pop_front();
          chk("sb_y", idx, y, w[7:0]);
          chk("sb_s", idx, {7'd0, s}, {7'd0, w[8]});
        end
      end
      if (r.v0 && r.er0) sb.push_back({1'b0, r.d0});
      if (r.v1 && r.er1) sb.push_back({1'b1, r.d1});
    end
    @(posedge clk);
    #1;
    chk("vld", idx, {7'd0, vld}, {7'd0, r.evld});
    chk("y", idx, y, r.ey);
    chk("s", idx, {7'd0, s}, {7'd0, r.es});
    m_vld = r.evld;
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rc;
    int         n;
    // fields: rst v0 d0 v1 d1 rdy | r0 r1 vld y s
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
`ifdef TDM_MUX_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 8'h11, 1, 8'h22, 1, 1, 0, 1, 8'h11, 0));
    tbl.push_back(mk(0, 0, 8'h11, 1, 8'h22, 1, 0, 1, 1, 8'h22, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h3C, 1, 0, 1, 1, 8'h3C, 1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 8'h99, 1, 8'h44, 0, 0, 0, 1, 8'h3C, 1));
    tbl.push_back(mk(0, 1, 8'h99, 1, 8'h44, 1, 1, 0, 1, 8'h99, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h99, 0));
`else
    tbl.push_back(mk(0, 1, 8'hA5, 0, 8'h00, 1, 1, 0, 1, 8'hA5, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(0, 1, 8'h11, 1, 8'h22, 1, (i % 2 == 0), (i % 2 == 1), 1,
                       (i % 2 == 0) ? 8'h11 : 8'h22, (i % 2 == 1)));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h3C, 1, 0, 1, 1, 8'h3C, 1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 8'h99, 0, 8'h00, 0, 0, 0, 1, 8'h3C, 1));
    tbl.push_back(mk(0, 1, 8'h99, 0, 8'h00, 1, 1, 0, 1, 8'h99, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h99, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h99, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h5A, 1, 0, 1, 1, 8'h5A, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 8'h5A, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 8'h77, 1, 8'h88, 1, 1, 0, 1, 8'h77, 0));
    tbl.push_back(mk(0, 1, 8'h77, 1, 8'h88, 1, 0, 1, 1, 8'h88, 1));
    tbl.push_back(mk(0, 1, 8'h77, 1, 8'h88, 0, 0, 0, 1, 8'h88, 1));
    tbl.push_back(mk(0, 1, 8'h77, 0, 8'h00, 0, 0, 0, 1, 8'h88, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h88, 1));
`endif
    n = 0;
    foreach (tbl[i]) begin
      run_row(tbl[i], n);
      n++;
    end

    // Stall with changing input data: held word must not move, then release arbitrates.
    ra = 8'($urandom_range(0, 255));
    rb = 8'($urandom_range(0, 255));
    rc = 8'($urandom_range(0, 255));
    run_row(mk(0, 1, ra, 0, 8'h00, 1, 1, 0, 1, ra, 0), n++);
    for (int i = 0; i < 3; i++) begin
      run_row(mk(0, 1, rb ^ 8'(i), 1, rc ^ 8'(i), 0, 0, 0, 1, ra, 0), n++);
    end
`ifdef TDM_MUX_FIXED_PRIO_EN
    run_row(mk(0, 1, rb, 1, rc, 1, 1, 0, 1, rb, 0), n++);
    run_row(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, rb, 0), n++);
`else
    run_row(mk(0, 1, rb, 1, rc, 1, 0, 1, 1, rc, 1), n++);
    run_row(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, rc, 1), n++);
`endif
    chk("sb_empty", n, 8'(sb.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
